seg_scan_capture: RTL and testbench

Receiving end of the multiplexed six-digit seven-segment scan bus driven by the clock display block. It samples the one-hot digit select and active-high segment pattern, decodes each pattern back to BCD, and reassembles complete HH:MM:SS frames. A frame commits to the six BCD outputs only after an in-order scan of digits 0..5. The block serves board-level loopback, self-check of the display path, and bench verification.

---
 rtl/seg_capture_pkg.sv | 48 ++++
 rtl/seg7_to_bcd.sv | 29 ++
 rtl/seg_scan_capture.sv | 156 +++++++++++++++
 tb/tb_seg_scan_capture.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_capture_pkg.sv
// Shared types and constants for the seven-segment scan capture block:
// segment codes, digit indices, FSM encoding and select-decoding helpers.
package seg_capture_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } cap_state_e;

    // Segment order is {a,b,c,d,e,f,g}, active high
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [2:0] IDX_TENS_HOURS   = 3'd0;
    localparam logic [2:0] IDX_HOURS        = 3'd1;
    localparam logic [2:0] IDX_TENS_MINUTES = 3'd2;
    localparam logic [2:0] IDX_MINUTES      = 3'd3;
    localparam logic [2:0] IDX_TENS_SECONDS = 3'd4;
    localparam logic [2:0] IDX_SECONDS      = 3'd5;

    localparam int NUM_DIGITS = 6;

    function automatic logic sel_is_onehot(input logic [5:0] sel);
        return (sel != 6'b0) && ((sel & (sel - 6'd1)) == 6'b0);
    endfunction

    // MSB of the select is digit 0, LSB is digit 5
    function automatic logic [2:0] sel_to_idx(input logic [5:0] sel);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) idx = 3'(NUM_DIGITS - 1 - i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment pattern to BCD decoder; any pattern outside
// the ten digit codes (blank included) is reported as invalid.
module seg7_to_bcd
    import seg_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output bcd_t       bcd
);

    always_comb begin
        valid = 1'b1;
        bcd   = 4'd0;
        case (seg)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Reassembles HH:MM:SS frames from a multiplexed seven-segment scan bus.
// Optional frame range validation: define SEG_CAPTURE_RANGE_CHECK_EN.
module seg_scan_capture
    import seg_capture_pkg::*;
(
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic [5:0] segment_sel,
    input  logic [6:0] seven_seg,
    output bcd_t       tens_hours,
    output bcd_t       hours,
    output bcd_t       tens_minutes,
    output bcd_t       minutes,
    output bcd_t       tens_seconds,
    output bcd_t       seconds,
    output logic       frame_valid,
    output logic       decode_err,
    output logic       sel_err,
    output logic       range_err
);

    logic [5:0] sel_p0;
    logic [6:0] seg_p0;
    logic       dig_vld_p0;
    bcd_t       dig_bcd_p0;
    logic       sel_idle_p0;
    logic       sel_onehot_p0;
    logic [2:0] sel_idx_p0;

    cap_state_e state_q, state_d;
    logic [2:0] exp_q, exp_d;
    // Digit 5 is never staged: it goes straight to the outputs on commit
    bcd_t       stage_q [NUM_DIGITS-1];
    logic       stage_we;
    logic       commit;
    logic       range_ok;
    logic       sel_err_d;
    logic       decode_err_d;

    seg7_to_bcd u_dec (
        .seg   (seg_p0),
        .valid (dig_vld_p0),
        .bcd   (dig_bcd_p0)
    );

    assign sel_idle_p0   = (sel_p0 == 6'b0);
    assign sel_onehot_p0 = sel_is_onehot(sel_p0);
    assign sel_idx_p0    = sel_to_idx(sel_p0);

    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        stage_we     = 1'b0;
        commit       = 1'b0;
        sel_err_d    = 1'b0;
        decode_err_d = 1'b0;
        case (state_q)
            HUNT: begin
                // Silently resynchronise: the scan may be joined mid-frame
                if (sel_onehot_p0 && sel_idx_p0 == IDX_TENS_HOURS && dig_vld_p0) begin
                    stage_we = 1'b1;
                    exp_d    = 3'd1;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (!sel_idle_p0) begin
                    if (!sel_onehot_p0) begin
                        sel_err_d = 1'b1;
                        state_d   = HUNT;
                        exp_d     = 3'd0;
                    end else if (!dig_vld_p0) begin
                        decode_err_d = 1'b1;
                        state_d      = HUNT;
                        exp_d        = 3'd0;
                    end else if (sel_idx_p0 == exp_q - 3'd1) begin
                        stage_we = 1'b1;
                    end else if (sel_idx_p0 == exp_q) begin
                        if (sel_idx_p0 == IDX_SECONDS) begin
                            commit  = 1'b1;
                            state_d = HUNT;
                            exp_d   = 3'd0;
                        end else begin
                            stage_we = 1'b1;
                            exp_d    = exp_q + 3'd1;
                        end
                    end else begin
                        sel_err_d = 1'b1;
                        state_d   = HUNT;
                        exp_d     = 3'd0;
                    end
                end
            end
            default: begin
                state_d = HUNT;
                exp_d   = 3'd0;
            end
        endcase
    end

`ifdef SEG_CAPTURE_RANGE_CHECK_EN
    assign range_ok = (stage_q[IDX_TENS_HOURS] <= 4'd2) &&
                      !(stage_q[IDX_TENS_HOURS] == 4'd2 && stage_q[IDX_HOURS] > 4'd3) &&
                      (stage_q[IDX_TENS_MINUTES] <= 4'd5) &&
                      (stage_q[IDX_TENS_SECONDS] <= 4'd5);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            range_err <= 1'b0;
        end else begin
            range_err <= commit && !range_ok;
        end
    end
`else
    assign range_ok  = 1'b1;
    assign range_err = 1'b0;
`endif

    // p0: pin capture; FSM, staging and outputs follow one edge later
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sel_p0       <= '0;
            seg_p0       <= '0;
            state_q      <= HUNT;
            exp_q        <= '0;
            for (int i = 0; i < NUM_DIGITS - 1; i++) stage_q[i] <= '0;
            tens_hours   <= '0;
            hours        <= '0;
            tens_minutes <= '0;
            minutes      <= '0;
            tens_seconds <= '0;
            seconds      <= '0;
            frame_valid  <= 1'b0;
            decode_err   <= 1'b0;
            sel_err      <= 1'b0;
        end else begin
            sel_p0      <= segment_sel;
            seg_p0      <= seven_seg;
            state_q     <= state_d;
            exp_q       <= exp_d;
            if (stage_we) stage_q[sel_idx_p0] <= dig_bcd_p0;
            frame_valid <= commit && range_ok;
            decode_err  <= decode_err_d;
            sel_err     <= sel_err_d;
            if (commit && range_ok) begin
                tens_hours   <= stage_q[IDX_TENS_HOURS];
                hours        <= stage_q[IDX_HOURS];
                tens_minutes <= stage_q[IDX_TENS_MINUTES];
                minutes      <= stage_q[IDX_MINUTES];
                tens_seconds <= stage_q[IDX_TENS_SECONDS];
                seconds      <= dig_bcd_p0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture against a frame-level reference model.
module tb_seg_scan_capture;

    logic       in_clk = 1'b0;
    logic       in_rst_n = 1'b0;
    logic [5:0] segment_sel = '0;
    logic [6:0] seven_seg = '0;
    logic [3:0] tens_hours, hours, tens_minutes, minutes, tens_seconds, seconds;
    logic       frame_valid, decode_err, sel_err, range_err;

    seg_scan_capture dut (
        .in_clk       (in_clk),
        .in_rst_n     (in_rst_n),
        .segment_sel  (segment_sel),
        .seven_seg    (seven_seg),
        .tens_hours   (tens_hours),
        .hours        (hours),
        .tens_minutes (tens_minutes),
        .minutes      (minutes),
        .tens_seconds (tens_seconds),
        .seconds      (seconds),
        .frame_valid  (frame_valid),
        .decode_err   (decode_err),
        .sel_err      (sel_err),
        .range_err    (range_err)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [5:0] sel;
        logic [6:0] seg;
    } stim_t;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    int          errors = 0;
    int          checks = 0;
    stim_t       stim[$];
    // Model state: digits gathered so far (empty = hunting), last committed frame
    int          got[$];
    logic [23:0] m_frame;
    // Expected pulses {frame_valid, decode_err, sel_err, range_err} and digits for next sample
    logic [3:0]  pend_p;
    logic [23:0] pend_d;

    function automatic int seg_val(input logic [6:0] s);
        for (int i = 0; i < 10; i++) if (s === seg_tab[i]) return i;
        return -1;
    endfunction

    function automatic bit frame_ok();
`ifdef SEG_CAPTURE_RANGE_CHECK_EN
        return (got[0] * 10 + got[1] <= 23) && (got[2] * 10 + got[3] <= 59) &&
               (got[4] * 10 + got[5] <= 59);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        got.delete();
        m_frame = '0;
        pend_p  = '0;
        pend_d  = '0;
    endtask

    task automatic model_sample(input logic [5:0] sel, input logic [6:0] seg);
        int d;
        int idx;
        int n;
        pend_p = '0;
        d = seg_val(seg);
        n = got.size();
        if (sel == 6'b0) begin
            // idle: nothing happens
        end else if (n == 0) begin
            if (sel == 6'b100000 && d >= 0) got.push_back(d);
        end else if ($countones(sel) != 1) begin
            pend_p[1] = 1'b1;
            got.delete();
        end else if (d < 0) begin
            pend_p[2] = 1'b1;
            got.delete();
        end else begin
            idx = 5 - $clog2(sel);
            if (idx == n - 1) begin
                got[n-1] = d;
            end else if (idx == n) begin
                got.push_back(d);
                if (got.size() == 6) begin
                    if (frame_ok()) begin
                        m_frame = '0;
                        foreach (got[i]) m_frame = (m_frame << 4) | 24'(got[i]);
                        pend_p[3] = 1'b1;
                    end else begin
                        pend_p[0] = 1'b1;
                    end
                    got.delete();
                end
            end else begin
                pend_p[1] = 1'b1;
                got.delete();
            end
        end
        pend_d = m_frame;
    endtask

    task automatic add_raw(input logic [5:0] sel, input logic [6:0] seg);
        stim_t e;
        e.sel = sel;
        e.seg = seg;
        stim.push_back(e);
    endtask

    task automatic add_digit(input int idx, input int val, input int reps);
        for (int r = 0; r < reps; r++) add_raw(6'b100000 >> idx, seg_tab[val]);
    endtask

    task automatic add_idle(input int n);
        for (int r = 0; r < n; r++) add_raw(6'b0, 7'b0);
    endtask

    task automatic add_frame(input logic [23:0] f, input int reps, input bit idle_between);
        for (int k = 0; k < 6; k++) begin
            add_digit(k, int'(f[23-4*k -: 4]), reps);
            if (idle_between) add_idle(1);
        end
    endtask

    // Drive one sample, observe outputs one edge later alongside the model's expectation
    task automatic step(input logic [5:0] sel, input logic [6:0] seg,
                        output logic [3:0] op, output logic [23:0] od,
                        output logic [3:0] ep, output logic [23:0] ed);
        segment_sel = sel;
        seven_seg   = seg;
        @(posedge in_clk);
        #1;
        op = {frame_valid, decode_err, sel_err, range_err};
        od = {tens_hours, hours, tens_minutes, minutes, tens_seconds, seconds};
        ep = pend_p;
        ed = pend_d;
        model_sample(sel, seg);
    endtask

    task automatic test_reset();
        logic [3:0]  op;
        logic [23:0] od;
        model_reset();
        repeat (2) @(posedge in_clk);
        #1;
        op = {frame_valid, decode_err, sel_err, range_err};
        od = {tens_hours, hours, tens_minutes, minutes, tens_seconds, seconds};
        checks++;
        if (op !== 4'b0) begin errors++; $display("FAIL reset_pulses got=%b want=0000", op); end
        checks++;
        if (od !== 24'h0) begin errors++; $display("FAIL reset_digits got=%h want=000000", od); end
        #3 in_rst_n = 1'b1;
    endtask

    task automatic test_clean_frame();
        logic [3:0]  op, ep;
        logic [23:0] od, ed;
        int fv = 0;
        int gap = 0;
        int last = -1;
        stim.delete();
        repeat (3) add_frame(24'h123456, 1, 1'b0);
        add_idle(2);
        foreach (stim[i]) begin
            step(stim[i].sel, stim[i].seg, op, od, ep, ed);
            checks++;
            if (op !== ep) begin errors++; $display("FAIL clean_pulses step=%0d got=%b want=%b", i, op, ep); end
            checks++;
            if (od !== ed) begin errors++; $display("FAIL clean_digits step=%0d got=%h want=%h", i, od, ed); end
            if (op[3]) begin
                if (last >= 0) gap = i - last;
                last = i;
            end
            fv += int'(op[3]);
        end
        checks++;
        if (fv != 3) begin errors++; $display("FAIL clean_count got=%0d want=3", fv); end
        checks++;
        if (gap != 6) begin errors++; $display("FAIL clean_period got=%0d want=6", gap); end
        checks++;
        if (od !== 24'h123456) begin errors++; $display("FAIL clean_value got=%h want=123456", od); end
    endtask

    task automatic test_midframe();
        logic [3:0]  op, ep;
        logic [23:0] od, ed;
        int fv = 0;
        int bad = 0;
        stim.delete();
        add_digit(3, 7, 1);
        add_digit(4, 1, 1);
        add_digit(5, 8, 1);
        add_frame(24'h204517, 1, 1'b0);
        add_idle(2);
        foreach (stim[i]) begin
            step(stim[i].sel, stim[i].seg, op, od, ep, ed);
            checks++;
            if (op !== ep) begin errors++; $display("FAIL mid_pulses step=%0d got=%b want=%b", i, op, ep); end
            checks++;
            if (od !== ed) begin errors++; $display("FAIL mid_digits step=%0d got=%h want=%h", i, od, ed); end
            fv += int'(op[3]);
            bad += int'(op[2] | op[1] | op[0]);
        end
        checks++;
        if (fv != 1 || bad != 0) begin errors++; $display("FAIL mid_count got=%0d/%0d want=1/0", fv, bad); end
        checks++;
        if (od !== 24'h204517) begin errors++; $display("FAIL mid_value got=%h want=204517", od); end
    endtask

    task automatic test_bad_pattern();
        logic [3:0]  op, ep;
        logic [23:0] od, ed;
        int de = 0;
        int fv = 0;
        stim.delete();
        add_digit(0, 0, 1);
        add_digit(1, 9, 1);
        add_raw(6'b001000, 7'b1010101);
        add_idle(2);
        add_frame(24'h081542, 1, 1'b0);
        add_idle(2);
        foreach (stim[i]) begin
            step(stim[i].sel, stim[i].seg, op, od, ep, ed);
            checks++;
            if (op !== ep) begin errors++; $display("FAIL badpat_pulses step=%0d got=%b want=%b", i, op, ep); end
            checks++;
            if (od !== ed) begin errors++; $display("FAIL badpat_digits step=%0d got=%h want=%h", i, od, ed); end
            de += int'(op[2]);
            fv += int'(op[3]);
        end
        checks++;
        if (de != 1 || fv != 1) begin errors++; $display("FAIL badpat_count got=%0d/%0d want=1/1", de, fv); end
    endtask

    task automatic test_sel_faults();
        logic [3:0]  op, ep;
        logic [23:0] od, ed;
        int se = 0;
        int fv = 0;
        stim.delete();
        add_digit(0, 1, 1);
        add_raw(6'b110000, seg_tab[3]);
        add_digit(0, 2, 1);
        add_digit(1, 3, 1);
        add_digit(3, 4, 1);
        add_idle(1);
        add_frame(24'h235959, 3, 1'b1);
        add_idle(2);
        foreach (stim[i]) begin
            step(stim[i].sel, stim[i].seg, op, od, ep, ed);
            checks++;
            if (op !== ep) begin errors++; $display("FAIL sel_pulses step=%0d got=%b want=%b", i, op, ep); end
            checks++;
            if (od !== ed) begin errors++; $display("FAIL sel_digits step=%0d got=%h want=%h", i, od, ed); end
            se += int'(op[1]);
            fv += int'(op[3]);
        end
        checks++;
        if (se != 2 || fv != 1) begin errors++; $display("FAIL sel_count got=%0d/%0d want=2/1", se, fv); end
        checks++;
        if (od !== 24'h235959) begin errors++; $display("FAIL sel_value got=%h want=235959", od); end
    endtask

    task automatic test_reset_mid();
        logic [3:0]  op, ep;
        logic [23:0] od, ed;
        int fv = 0;
        stim.delete();
        add_digit(0, 1, 1);
        add_digit(1, 1, 1);
        add_digit(2, 4, 1);
        foreach (stim[i]) step(stim[i].sel, stim[i].seg, op, od, ep, ed);
        in_rst_n = 1'b0;
        #2;
        op = {frame_valid, decode_err, sel_err, range_err};
        od = {tens_hours, hours, tens_minutes, minutes, tens_seconds, seconds};
        checks++;
        if (op !== 4'b0) begin errors++; $display("FAIL rstmid_pulses got=%b want=0000", op); end
        checks++;
        if (od !== 24'h0) begin errors++; $display("FAIL rstmid_digits got=%h want=000000", od); end
        model_reset();
        #2 in_rst_n = 1'b1;
        stim.delete();
        add_digit(3, 2, 1);
        add_digit(4, 3, 1);
        add_digit(5, 7, 1);
        add_idle(2);
        foreach (stim[i]) begin
            step(stim[i].sel, stim[i].seg, op, od, ep, ed);
            checks++;
            if (op !== ep) begin errors++; $display("FAIL rstmid_after_pulses step=%0d got=%b want=%b", i, op, ep); end
            fv += int'(op[3]);
        end
        checks++;
        if (fv != 0 || od !== 24'h0) begin errors++; $display("FAIL rstmid_commit got=%0d/%h want=0/000000", fv, od); end
    endtask

    task automatic test_range();
        logic [3:0]  op, ep;
        logic [23:0] od, ed;
        int fv = 0;
        int re = 0;
        stim.delete();
        add_frame(24'h100709, 1, 1'b0);
        add_frame(24'h290000, 1, 1'b0);
        add_idle(2);
        foreach (stim[i]) begin
            step(stim[i].sel, stim[i].seg, op, od, ep, ed);
            checks++;
            if (op !== ep) begin errors++; $display("FAIL range_pulses step=%0d got=%b want=%b", i, op, ep); end
            checks++;
            if (od !== ed) begin errors++; $display("FAIL range_digits step=%0d got=%h want=%h", i, od, ed); end
            fv += int'(op[3]);
            re += int'(op[0]);
        end
`ifdef SEG_CAPTURE_RANGE_CHECK_EN
        checks++;
        if (fv != 1 || re != 1 || od !== 24'h100709) begin
            errors++; $display("FAIL range_on got=%0d/%0d/%h want=1/1/100709", fv, re, od);
        end
`else
        checks++;
        if (fv != 2 || re != 0 || od !== 24'h290000) begin
            errors++; $display("FAIL range_off got=%0d/%0d/%h want=2/0/290000", fv, re, od);
        end
`endif
    endtask

    task automatic test_random();
        logic [3:0]  op, ep;
        logic [23:0] od, ed;
        int start;
        int r;
        stim.delete();
        for (int f = 0; f < 60; f++) begin
            start = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 5)) : 0;
            for (int k = start; k < 6; k++) begin
                r = int'($urandom_range(0, 39));
                if (r == 0) add_raw(6'($urandom_range(0, 63)), seg_tab[$urandom_range(0, 9)]);
                else if (r == 1) add_raw(6'b100000 >> k, 7'($urandom_range(0, 127)));
                else if (r == 2) begin end
                else begin
                    if (r < 7) add_idle(1);
                    add_digit(k, int'($urandom_range(0, 9)), int'($urandom_range(1, 3)));
                end
            end
        end
        add_idle(2);
        foreach (stim[i]) begin
            step(stim[i].sel, stim[i].seg, op, od, ep, ed);
            checks++;
            if (op !== ep) begin errors++; $display("FAIL rand_pulses step=%0d got=%b want=%b", i, op, ep); end
            checks++;
            if (od !== ed) begin errors++; $display("FAIL rand_digits step=%0d got=%h want=%h", i, od, ed); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_midframe();
        test_bad_pattern();
        test_sel_faults();
        test_reset_mid();
        test_range();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
